video_timing_gen: RTL

- Raster timing generator that sits directly upstream of the per-channel TMDS encoders.
- Produces ACTIVE/HSYNC/VSYNC in the form the encoders consume, plus a pixel-request/coordinate stream for the framebuffer read port.
- The request stream leads ACTIVE by a programmable number of cycles, which absorbs framebuffer read latency so the fetched pixel lands on the encoders' DATA input aligned with ACTIVE.

---
 rtl/video_timing_gen.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/video_timing_gen.sv
// video_timing_gen: raster timing generator feeding the TMDS encoders.
// The request stage (REQ/X/Y/LINE_START/FRAME_START) runs LEAD cycles ahead of
// the encoder stage (ACTIVE/HSYNC/VSYNC/RED/GREEN/BLUE) so framebuffer read
// latency is hidden.
// Optional colour-bar test pattern: define VIDEO_TIMING_GEN_TPG_EN.
module video_timing_gen #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0,
    parameter int LEAD      = 2
) (
    input  logic        PIXEL_CLK,
    input  logic        RESET,
    output logic        REQ,
    output logic [11:0] X,
    output logic [11:0] Y,
    output logic        LINE_START,
    output logic        FRAME_START,
    output logic        ACTIVE,
    output logic        HSYNC,
    output logic        VSYNC,
    output logic [7:0]  RED,
    output logic [7:0]  GREEN,
    output logic [7:0]  BLUE
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);
    localparam logic [11:0] H_VIS  = 12'(H_ACTIVE);
    localparam logic [11:0] V_VIS  = 12'(V_ACTIVE);
    localparam logic [11:0] HS_BEG = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HS_END = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] VS_BEG = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] VS_END = 12'(V_ACTIVE + V_FP + V_SYNC);

    // Encoder-stage bundle: {active, hsync, vsync, red, green, blue}
    localparam int ENC_W = 27;
    localparam logic [ENC_W-1:0] ENC_IDLE = {1'b0, ~HSYNC_POL, ~VSYNC_POL, 24'd0};

    logic [11:0] h;
    logic [11:0] v;
    logic        vis;
    logic        hs_dec;
    logic        vs_dec;
    logic [23:0] rgb_dec;

    // Raster position counters; v steps when h wraps
    always_ff @(posedge PIXEL_CLK) begin
        if (RESET) begin
            h <= '0;
            v <= '0;
        end else if (h == H_LAST) begin
            h <= '0;
            v <= (v == V_LAST) ? 12'd0 : v + 12'd1;
        end else begin
            h <= h + 12'd1;
        end
    end

    assign vis    = (h < H_VIS) && (v < V_VIS);
    assign hs_dec = ((h >= HS_BEG) && (h < HS_END)) ? HSYNC_POL : ~HSYNC_POL;
    assign vs_dec = ((v >= VS_BEG) && (v < VS_END)) ? VSYNC_POL : ~VSYNC_POL;

`ifdef VIDEO_TIMING_GEN_TPG_EN
    localparam logic [11:0] BAR_LAST = 12'(H_ACTIVE / 8 - 1);

    logic [2:0]  bar;
    logic [11:0] bar_cnt;
    logic [2:0]  colour;

    // Bar index tracks h: cleared at line start, steps every H_ACTIVE/8 visible pixels
    always_ff @(posedge PIXEL_CLK) begin
        if (RESET || (h == H_LAST)) begin
            bar     <= '0;
            bar_cnt <= '0;
        end else if (h < H_VIS) begin
            if (bar_cnt == BAR_LAST) begin
                bar     <= bar + 3'd1;
                bar_cnt <= '0;
            end else begin
                bar_cnt <= bar_cnt + 12'd1;
            end
        end
    end

    assign colour  = 3'd7 - bar;
    assign rgb_dec = vis ? {{8{colour[2]}}, {8{colour[1]}}, {8{colour[0]}}} : 24'd0;
`else
    assign rgb_dec = 24'd0;
`endif

    logic             req_p0;
    logic [11:0]      x_p0;
    logic [11:0]      y_p0;
    logic             line_start_p0;
    logic             frame_start_p0;
    logic [ENC_W-1:0] enc_p0;
    logic [ENC_W-1:0] enc_out;

    // Request stage: registered decode of the current position
    always_ff @(posedge PIXEL_CLK) begin
        if (RESET) begin
            req_p0         <= 1'b0;
            x_p0           <= '0;
            y_p0           <= '0;
            line_start_p0  <= 1'b0;
            frame_start_p0 <= 1'b0;
            enc_p0         <= ENC_IDLE;
        end else begin
            req_p0         <= vis;
            x_p0           <= vis ? h : 12'd0;
            y_p0           <= vis ? v : 12'd0;
            line_start_p0  <= (h == 12'd0);
            frame_start_p0 <= (h == 12'd0) && (v == 12'd0);
            enc_p0         <= {vis, hs_dec, vs_dec, rgb_dec};
        end
    end

    // Encoder stage: LEAD-deep shift chain behind the request stage
    generate
        if (LEAD == 0) begin : g_no_lead
            assign enc_out = enc_p0;
        end else begin : g_lead
            logic [ENC_W-1:0] enc_dly [LEAD];

            // Shift chain, flushed to idle values by reset
            always_ff @(posedge PIXEL_CLK) begin
                if (RESET) begin
                    for (int i = 0; i < LEAD; i++) enc_dly[i] <= ENC_IDLE;
                end else begin
                    enc_dly[0] <= enc_p0;
                    for (int i = 1; i < LEAD; i++) enc_dly[i] <= enc_dly[i-1];
                end
            end

            assign enc_out = enc_dly[LEAD-1];
        end
    endgenerate

    assign REQ         = req_p0;
    assign X           = x_p0;
    assign Y           = y_p0;
    assign LINE_START  = line_start_p0;
    assign FRAME_START = frame_start_p0;
    assign ACTIVE      = enc_out[26];
    assign HSYNC       = enc_out[25];
    assign VSYNC       = enc_out[24];
    assign RED         = enc_out[23:16];
    assign GREEN       = enc_out[15:8];
    assign BLUE        = enc_out[7:0];

endmodule
